// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational alu between two requesters
//
// Purpose:
//   Accepts one operation at a time from two requesters. When both present an
//   operation, the one that was not served last wins. The accepted operands
//   are registered and held on alu_* for EXEC_CYCLES cycles. The alu result is
//   then captured into rsp_s/rsp_z and offered back to the winning requester
//   with a valid/ready handshake.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (ready is combinational)
//   reqN_a, reqN_b, reqN_aluc    requester N operands and opcode
//   rspN_valid / rspN_ready      response handshake for requester N
//   rsp_s, rsp_z                 registered result and zero flag, shared by both responses
//   alu_a, alu_b, alu_aluc       registered operands driving the external alu
//   alu_s, alu_z                 external alu outputs
//   busy                         high whenever an operation is in flight

module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_aluc,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // The counter runs from EXEC_CYCLES-1 down to 0; a request for zero
    // cycles is treated the same as one cycle.
    localparam logic [7:0] CNT_LOAD = (EXEC_CYCLES <= 1) ? 8'd0 : 8'(EXEC_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;     // id of the requester favoured on a tie
    logic             gid_q, gid_d;     // id of the requester currently being served
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d;

    logic grant;
    logic idle;
    logic accept;
    logic rsp_hs;

    assign idle = (state_q == S_IDLE);

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = (state_q == S_RESP) && !gid_q;
    assign rsp1_valid = (state_q == S_RESP) && gid_q;
    // The non-granted requester's rsp_ready never reaches the FSM.
    assign rsp_hs     = gid_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s_d     = s_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = grant ? req1_a    : req0_a;
                    b_d     = grant ? req1_b    : req0_b;
                    c_d     = grant ? req1_aluc : req0_aluc;
                    gid_d   = grant;
                    cnt_d   = CNT_LOAD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    s_d     = alu_s;
                    z_d     = alu_z;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    ptr_d   = ~gid_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            cnt_q   <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 4'd0;
            s_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s_q     <= s_d;
            z_q     <= z_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_aluc = c_q;
    assign rsp_s    = s_q;
    assign rsp_z    = z_q;
    assign busy     = !idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter

module tb_alu_share_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // ---------------- main instance, EXEC_CYCLES = 1 ----------------
    logic        v[2];
    logic [31:0] ra[2];
    logic [31:0] rb[2];
    logic [3:0]  rc[2];
    logic        rr[2];
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_z, busy;
    logic [31:0] rsp_s, alu_a, alu_b, alu_s;
    logic [3:0]  alu_aluc;
    logic        alu_z;
    logic [1:0]  rv;
    logic [1:0]  rdy;

    assign rv  = {rsp1_valid, rsp0_valid};
    assign rdy = {req1_ready, req0_ready};

    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] s;
        case (op)
            4'd0:    s = a + b;
            4'd1:    s = a - b;
            4'd2:    s = a & b;
            4'd3:    s = a | b;
            4'd4:    s = a ^ b;
            default: s = a;
        endcase
        return {(s == 32'd0), s};
    endfunction

    assign {alu_z, alu_s} = alu_ref(alu_a, alu_b, alu_aluc);

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_aluc(rc[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_aluc(rc[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]),
        .rsp_s(rsp_s), .rsp_z(rsp_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z),
        .busy(busy)
    );

    // ---------------- second instance, EXEC_CYCLES = 3 ----------------
    logic        t_v0, t_rr0;
    logic [31:0] t_a0, t_b0, x3;
    logic        t_rdy0, t_rdy1, t_rv0, t_rv1, t_z, t_busy;
    logic [31:0] t_s, t_alu_a, t_alu_b;
    logic [3:0]  t_alu_c;

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .req0_valid(t_v0), .req0_ready(t_rdy0), .req0_a(t_a0), .req0_b(t_b0), .req0_aluc(4'd0),
        .req1_valid(1'b0), .req1_ready(t_rdy1), .req1_a(32'd0), .req1_b(32'd0), .req1_aluc(4'd0),
        .rsp0_valid(t_rv0), .rsp0_ready(t_rr0), .rsp1_valid(t_rv1), .rsp1_ready(1'b0),
        .rsp_s(t_s), .rsp_z(t_z),
        .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_aluc(t_alu_c), .alu_s(x3), .alu_z(x3 == 32'd0),
        .busy(t_busy)
    );

    // ---------------- model state ----------------
    int fav = 0;   // requester that wins a tie

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Runs one operation on the main instance from the request setup already
    // placed in v/ra/rb/rc. Called at a negedge with the DUT idle.
    task automatic do_op(input int stall, input bit poke_other);
        int g;
        logic [32:0] e;
        #1;
        if (v[0] && v[1]) g = fav;
        else if (v[1])    g = 1;
        else              g = 0;
        e = alu_ref(ra[g], rb[g], rc[g]);
        chk("idle_busy", busy, 0);
        chk("idle_rdy0", req0_ready, v[0] && g == 0);
        chk("idle_rdy1", req1_ready, v[1] && g == 1);
        cyc();
        v[g] = 1'b0;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_alu_a", alu_a, ra[g]);
        chk("exec_alu_b", alu_b, rb[g]);
        chk("exec_aluc", alu_aluc, rc[g]);
        chk("exec_rdy", rdy, 0);
        chk("exec_rv", rv, 0);
        cyc();
        chk("resp_rv", rv, (g == 1) ? 2'b10 : 2'b01);
        chk("resp_s", rsp_s, e[31:0]);
        chk("resp_z", rsp_z, e[32]);
        for (int i = 0; i < stall; i++) begin
            rr[1-g] = poke_other;
            cyc();
            chk("hold_rv", rv, (g == 1) ? 2'b10 : 2'b01);
            chk("hold_s", rsp_s, e[31:0]);
            chk("hold_rdy", rdy, 0);
            chk("hold_busy", busy, 1);
        end
        rr[1-g] = 1'b0;
        rr[g]   = 1'b1;
        cyc();
        rr[g] = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_rv", rv, 0);
        fav = 1 - g;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        v[id]  = 1'b1;
        ra[id] = a;
        rb[id] = b;
        rc[id] = c;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; ra[i] = 0; rb[i] = 0; rc[i] = 0; rr[i] = 0;
        end
        t_v0 = 0; t_a0 = 0; t_b0 = 0; t_rr0 = 0; x3 = 0;

        // reset values
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_rv", rv, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_s", rsp_s, 0);
        chk("rst_rsp_z", rsp_z, 0);
        reset = 1'b0;

        // test 1: 5 + 7
        set_req(0, 32'd5, 32'd7, 4'd0);
        do_op(0, 0);

        // test 2: simultaneous, req0 favoured after reset
        reset = 1'b1; #1; reset = 1'b0; fav = 0;
        set_req(0, 32'd9, 32'd9, 4'd1);
        set_req(1, 32'hF0, 32'h0F, 4'd3);
        do_op(0, 0);
        do_op(0, 0);

        // test 3: both valid continuously, alternation 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            if (!v[0]) set_req(0, $urandom, $urandom, 4'($urandom_range(0, 5)));
            if (!v[1]) set_req(1, $urandom, $urandom, 4'($urandom_range(0, 5)));
            do_op(0, 0);
        end
        v[0] = 0; v[1] = 0;

        // test 4: back-pressure for 5 cycles with req1 waiting
        set_req(0, 32'd100, 32'd1, 4'd1);
        v[1] = 1'b0;
        #1;
        if (fav != 0) begin
            set_req(1, 32'd1, 32'd1, 4'd0);
            do_op(0, 0);
        end
        set_req(0, 32'd100, 32'd1, 4'd1);
        set_req(1, 32'd3, 32'd3, 4'd4);
        do_op(5, 1);
        do_op(0, 0);

        // test 6a: reset during EXEC
        set_req(1, 32'd8, 32'd2, 4'd0);
        #1;
        chk("r6_rdy1", req1_ready, 1);
        cyc();
        v[1] = 1'b0;
        reset = 1'b1;
        #1;
        chk("r6_exec_busy", busy, 0);
        chk("r6_exec_rv", rv, 0);
        chk("r6_exec_alu_a", alu_a, 0);
        cyc();
        reset = 1'b0;
        fav = 0;
        chk("r6_no_rsp", rv, 0);
        // test 6b: reset during RESP
        set_req(1, 32'd6, 32'd6, 4'd3);
        cyc();
        v[1] = 1'b0;
        cyc();
        chk("r6_resp_rv", rv, 2'b10);
        reset = 1'b1;
        #1;
        chk("r6_resp_rv_drop", rv, 0);
        chk("r6_resp_s", rsp_s, 0);
        cyc();
        reset = 1'b0;
        fav = 0;
        cyc();
        chk("r6_after_rv", rv, 0);
        set_req(0, 32'd20, 32'd22, 4'd0);
        set_req(1, 32'd1, 32'd2, 4'd0);
        do_op(0, 0);
        do_op(0, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            v[0] = 1'($urandom_range(0, 1));
            v[1] = 1'($urandom_range(0, 1));
            if (!v[0] && !v[1]) begin
                #1;
                chk("rnd_idle_rdy", rdy, 0);
                chk("rnd_idle_busy", busy, 0);
                cyc();
                v[$urandom_range(0, 1)] = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                ra[i] = ($urandom_range(0, 3) == 0) ? rb[i] : $urandom;
                rb[i] = $urandom;
                rc[i] = 4'($urandom_range(0, 5));
            end
            do_op($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        v[0] = 0; v[1] = 0;

        // test 5: EXEC_CYCLES=3, only the alu value at edge E+3 is captured
        t_v0 = 1'b1; t_a0 = 32'd3; t_b0 = 32'd4;
        #1;
        chk("e3_rdy", t_rdy0, 1);
        cyc();                       // edge E
        t_v0 = 1'b0; x3 = 32'd111;
        #1;
        chk("e3_busy", t_busy, 1);
        chk("e3_alu_a", t_alu_a, 3);
        cyc();                       // E+1
        x3 = 32'd222;
        chk("e3_rv_1", t_rv0, 0);
        cyc();                       // E+2
        x3 = 32'd333;
        chk("e3_rv_2", t_rv0, 0);
        chk("e3_alu_b", t_alu_b, 4);
        cyc();                       // E+3 capture
        x3 = 32'd444;
        #1;
        chk("e3_rv_3", t_rv0, 1);
        chk("e3_s", t_s, 333);
        chk("e3_z", t_z, 0);
        t_rr0 = 1'b1;
        cyc();
        t_rr0 = 1'b0;
        #1;
        chk("e3_done_busy", t_busy, 0);
        chk("e3_done_s", t_s, 333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
